// File: rtl/mult_pkg.sv
// Shared types and sizing for the 4x4 sequential multiplier slice.
package mult_pkg;
  localparam int MULT_W     = 4;
  localparam int MULT_STEPS = 4;
  localparam int CNT_W      = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/seq_mult_4_if.sv
// start/ready/done handshake bundle between ALU control and seq_mult_4.
interface seq_mult_4_if;
  import mult_pkg::*;

  logic                  start;
  logic [MULT_W-1:0]     a;
  logic [MULT_W-1:0]     b;
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic [2*MULT_W-1:0]   p;

  modport master (output start, a, b, input ready, busy, done, p);
  modport slave  (input start, a, b, output ready, busy, done, p);
endinterface

// File: rtl/adder_4_s.sv
// 4-bit ripple-carry adder with signed overflow flag.
// Latency: combinational.
// Backpressure: none.
module adder_4_s (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       ovf
);
  logic [4:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]);
    end
  end

  assign ovf = c[3] ^ c[4];
endmodule

// File: rtl/mult_4_addstep.sv
// One shift-and-add partial sum: {c,sum} = acc + (mq0 ? mcand : 0).
// Latency: combinational.
// Backpressure: none.
module mult_4_addstep
  import mult_pkg::*;
(
  input  logic [MULT_W-1:0] acc,
  input  logic [MULT_W-1:0] mcand,
  input  logic              mq0,
  output logic [MULT_W:0]   csum
);
  logic [MULT_W-1:0] addend;
  logic [MULT_W-1:0] sum;
  logic              unused_ovf;
  logic              c;

  assign addend = mcand & {MULT_W{mq0}};

  adder_4_s u_adder (
    .a   (acc),
    .b   (addend),
    .cin (1'b0),
    .s   (sum),
    .ovf (unused_ovf)
  );

  // The adder has no carry-out port; recover it from the MSBs and the sum.
  assign c    = (acc[MULT_W-1] & addend[MULT_W-1]) |
                ((acc[MULT_W-1] ^ addend[MULT_W-1]) & ~sum[MULT_W-1]);
  assign csum = {c, sum};
endmodule

// File: rtl/seq_mult_4.sv
// Sequential 4x4 unsigned shift-and-add multiplier; MULT_EARLY_EXIT_EN skips trailing zero steps.
// Latency: 5 edges start-to-done (fewer with early exit); one product per 5 cycles back-to-back.
// Backpressure: start only sampled while ready; starts during CALC are dropped.
module seq_mult_4
  import mult_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  seq_mult_4_if.slave    bus
);
  state_t              state, state_nxt;
  logic [MULT_W-1:0]   mcand;
  logic [MULT_W-1:0]   acc;
  logic [MULT_W-1:0]   mq;
  logic [CNT_W-1:0]    cnt;
  logic [MULT_W:0]     csum;
  logic                accept;
  logic                last_step;
  logic                exit_now;

  mult_4_addstep u_addstep (
    .acc   (acc),
    .mcand (mcand),
    .mq0   (mq[0]),
    .csum  (csum)
  );

  assign accept    = bus.ready & bus.start;
  assign last_step = (cnt == CNT_W'(MULT_STEPS - 1));

`ifdef MULT_EARLY_EXIT_EN
  logic [MULT_W-1:0]   rem_mask;
  logic [2*MULT_W-1:0] shifted;

  // Low (4-cnt) bits of mq are multiplier bits not yet consumed.
  assign rem_mask = {MULT_W{1'b1}} >> cnt;
  assign exit_now = ((mq & rem_mask) == '0);
  assign shifted  = {acc, mq} >> (CNT_W'(MULT_W) - cnt);
`else
  assign exit_now = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (last_step || exit_now) state_nxt = DONE;
      DONE:    state_nxt = accept ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand <= '0;
      acc   <= '0;
      mq    <= '0;
      cnt   <= '0;
    end else if (accept) begin
      mcand <= bus.a;
      acc   <= '0;
      mq    <= bus.b;
      cnt   <= '0;
    end else if (state == CALC) begin
`ifdef MULT_EARLY_EXIT_EN
      if (exit_now) begin
        {acc, mq} <= shifted;
        cnt       <= cnt + 1'b1;
      end else begin
        {acc, mq} <= {csum, mq[MULT_W-1:1]};
        cnt       <= cnt + 1'b1;
      end
`else
      {acc, mq} <= {csum, mq[MULT_W-1:1]};
      cnt       <= cnt + 1'b1;
`endif
    end
  end

  assign bus.ready = (state != CALC);
  assign bus.busy  = (state == CALC);
  assign bus.done  = (state == DONE);
  assign bus.p     = {acc, mq};
endmodule

// File: tb/tb_seq_mult_4.sv
// Directed and exhaustive checks of seq_mult_4 in either build of MULT_EARLY_EXIT_EN.
module tb_seq_mult_4;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miss    = 0;
  int   done_cnt = 0;

  seq_mult_4_if bus ();

  seq_mult_4 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  function automatic int exp_cyc(input logic [3:0] bv);
`ifdef MULT_EARLY_EXIT_EN
    if (bv == 4'd0) return 2;
    if (bv == 4'd1) return 3;
    if (bv < 4'd4)  return 4;
    return 5;
`else
    return 5;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Call just after a negedge; returns one tick after the accepting edge.
  task automatic launch(input logic [3:0] ia, input logic [3:0] ib);
    bus.start = 1'b1;
    bus.a     = ia;
    bus.b     = ib;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int rdy_low);
    cyc     = 0;
    rdy_low = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (bus.ready === 1'b0) rdy_low++;
    end while (bus.done !== 1'b1 && cyc < 30);
  endtask

  initial begin
    int cyc, rl, d0;
    logic [7:0] expp;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_busy",  32'(bus.busy),  32'd0);
    chk("rst_done",  32'(bus.done),  32'd0);
    chk("rst_p",     32'(bus.p),     32'h00);
    rst = 1'b0;
    @(negedge clk);

    // 15 x 15
    launch(4'hF, 4'hF);
    wait_done(cyc, rl);
    chk("ff_p",         32'(bus.p), 32'hE1);
    chk("ff_latency",   cyc,        32'd5);
    chk("ff_ready_low", rl,         32'd4);

    // 7 x 3, then back-to-back start in DONE with 9 x 0
    launch(4'h7, 4'h3);
    wait_done(cyc, rl);
    chk("73_p",       32'(bus.p), 32'h15);
    chk("73_latency", cyc,        32'(exp_cyc(4'h3)));
    launch(4'h9, 4'h0);
    wait_done(cyc, rl);
    chk("90_p",       32'(bus.p), 32'h00);
    chk("90_latency", cyc,        32'(exp_cyc(4'h0)));

    // 5 x 6 with a stray start during CALC
    @(negedge clk);
    d0 = done_cnt;
    launch(4'h5, 4'h6);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 4'h1;
    bus.b = 4'h1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(cyc, rl);
    chk("56_p",       32'(bus.p), 32'h1E);
    chk("56_latency", cyc + 2,    32'd5);
    repeat (4) @(negedge clk);
    #1 chk("56_one_done", done_cnt - d0, 32'd1);

    // Reset in the middle of step 3 of 15 x 15
    d0 = done_cnt;
    launch(4'hF, 4'hF);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_ready", 32'(bus.ready), 32'd1);
    chk("abort_busy",  32'(bus.busy),  32'd0);
    chk("abort_done",  32'(bus.done),  32'd0);
    chk("abort_p",     32'(bus.p),     32'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    #1 chk("abort_no_done", done_cnt - d0, 32'd0);

`ifdef MULT_EARLY_EXIT_EN
    launch(4'hF, 4'h1);
    wait_done(cyc, rl);
    chk("ee_f1_p",   32'(bus.p), 32'h0F);
    chk("ee_f1_cyc", cyc,        32'd3);
    launch(4'hF, 4'h8);
    wait_done(cyc, rl);
    chk("ee_f8_p",   32'(bus.p), 32'h78);
    chk("ee_f8_cyc", cyc,        32'd5);
`endif

    // Exhaustive sweep, issued back-to-back from each DONE cycle
    @(negedge clk);
    d0 = done_cnt;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        expp = 8'(ia * ib);
        launch(4'(ia), 4'(ib));
        wait_done(cyc, rl);
        chk($sformatf("sweep_p_%0d_%0d", ia, ib),   32'(bus.p), 32'(expp));
        chk($sformatf("sweep_cyc_%0d_%0d", ia, ib), cyc,        32'(exp_cyc(4'(ib))));
      end
    end
    repeat (3) @(negedge clk);
    #1 chk("sweep_done_count", done_cnt - d0, 32'd256);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
